// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//   Main control FSM for the multicycle MIPS datapath. Steps each instruction
//   through fetch / decode / execute / memory / writeback. It drives the ALU
//   operation class, all datapath mux selects and all write enables. Memory
//   accesses (fetch, load, store) hold their state until mem_ready is seen.
//
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   opcode[5:0]       instr[31:26] from the IR, stable from DECODE onward
//   zero              ALU zero flag (used by BEQ)
//   mem_ready         memory finished the current read/write this cycle
//   alu_op[2:0]       000 add, 001 sub, 010 R-type funct decode
//   alu_src_a         0=PC, 1=reg A
//   alu_src_b[1:0]    00=reg B, 01=4, 10=sext imm, 11=sext imm<<2
//   pc_src[1:0]       00=ALU result, 01=ALUOut, 10=jump target
//   iord              memory address 0=PC, 1=ALUOut
//   mem_read/_write   memory request strobes
//   ir_write          IR load
//   reg_dst           0=rt, 1=rd
//   mem_to_reg        0=ALUOut, 1=MDR
//   reg_write         register file write enable
//   pc_en             PC load enable, branch condition already folded in
//   illegal_op        one-cycle pulse in DECODE on an unsupported opcode
//   state_o[3:0]      current state code (debug)
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXE   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JMP    = 4'd11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_R   = 3'b010;

    logic [3:0] r_state;
    logic [3:0] w_next;

    logic [2:0] w_alu_op;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_pc_src;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_pc_en;
    logic       w_illegal_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and raw output decode. Everything defaults to 0 so that any
    // signal not named in a state stays inactive.
    always_comb begin
        w_next       = S_FETCH;
        w_alu_op     = ALU_ADD;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_pc_en      = 1'b0;
        w_illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 is computed while the instruction is read; PC and IR
                // are only committed on the cycle memory delivers.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = mem_ready;
                w_pc_en     = mem_ready;
                w_next      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut for a possible BEQ.
                w_alu_src_b = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    w_next = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    w_next = S_REXE;
                end else if (opcode == OP_BEQ) begin
                    w_next = S_BEQ;
                end else if (opcode == OP_ADDI) begin
                    w_next = S_ADDIEX;
                end else if (opcode == OP_J) begin
                    w_next = S_JMP;
                end else begin
                    w_illegal_op = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                // Only LW/SW reach here, so anything not SW is a load.
                w_next      = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
                w_next     = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                // Write strobe held for every wait cycle until acknowledged.
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                w_next      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_REXE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_R;
                w_next      = S_RWB;
            end
            S_RWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_SUB;
                w_pc_src    = 2'b01;
                w_pc_en     = zero;
                w_next      = S_FETCH;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JMP: begin
                w_pc_src = 2'b10;
                w_pc_en  = 1'b1;
                w_next   = S_FETCH;
            end
            default: begin
                // Unused codes 12-15: recover to FETCH with outputs idle.
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset gates every output directly so that an access abandoned by a
    // mid-cycle reset cannot leak a strobe or write enable.
    assign alu_op     = rst ? 3'b000 : w_alu_op;
    assign alu_src_a  = rst ? 1'b0   : w_alu_src_a;
    assign alu_src_b  = rst ? 2'b00  : w_alu_src_b;
    assign pc_src     = rst ? 2'b00  : w_pc_src;
    assign iord       = rst ? 1'b0   : w_iord;
    assign mem_read   = rst ? 1'b0   : w_mem_read;
    assign mem_write  = rst ? 1'b0   : w_mem_write;
    assign ir_write   = rst ? 1'b0   : w_ir_write;
    assign reg_dst    = rst ? 1'b0   : w_reg_dst;
    assign mem_to_reg = rst ? 1'b0   : w_mem_to_reg;
    assign reg_write  = rst ? 1'b0   : w_reg_write;
    assign pc_en      = rst ? 1'b0   : w_pc_en;
    assign illegal_op = rst ? 1'b0   : w_illegal_op;
    assign state_o    = rst ? 4'd0   : r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control
//   Directed stimulus; each cycle's hand-computed output vector is queued and
//   a separate monitor compares it against the DUT on the falling edge.
//   Vector layout: {state[3:0], alu_op[2:0], src_a, src_b[1:0], pc_src[1:0],
//                   iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//                   reg_write, pc_en, illegal_op}
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, pc_en, illegal_op;
    logic [3:0] state_o;

    mips_multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .pc_en(pc_en), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    //                             st     aluop  a     b      pc     iord..ill
    localparam logic [20:0] E_ZERO    = 21'd0;
    localparam logic [20:0] E_FETCH_R = {4'd0,  3'b000, 1'b0, 2'b01, 2'b00, 9'b010100010};
    localparam logic [20:0] E_FETCH_W = {4'd0,  3'b000, 1'b0, 2'b01, 2'b00, 9'b010000000};
    localparam logic [20:0] E_DEC     = {4'd1,  3'b000, 1'b0, 2'b11, 2'b00, 9'b000000000};
    localparam logic [20:0] E_DEC_ILL = {4'd1,  3'b000, 1'b0, 2'b11, 2'b00, 9'b000000001};
    localparam logic [20:0] E_MEMADR  = {4'd2,  3'b000, 1'b1, 2'b10, 2'b00, 9'b000000000};
    localparam logic [20:0] E_MEMRD   = {4'd3,  3'b000, 1'b0, 2'b00, 2'b00, 9'b110000000};
    localparam logic [20:0] E_MEMWB   = {4'd4,  3'b000, 1'b0, 2'b00, 2'b00, 9'b000001100};
    localparam logic [20:0] E_MEMWR   = {4'd5,  3'b000, 1'b0, 2'b00, 2'b00, 9'b101000000};
    localparam logic [20:0] E_REXE    = {4'd6,  3'b010, 1'b1, 2'b00, 2'b00, 9'b000000000};
    localparam logic [20:0] E_RWB     = {4'd7,  3'b000, 1'b0, 2'b00, 2'b00, 9'b000010100};
    localparam logic [20:0] E_BEQ1    = {4'd8,  3'b001, 1'b1, 2'b00, 2'b01, 9'b000000010};
    localparam logic [20:0] E_BEQ0    = {4'd8,  3'b001, 1'b1, 2'b00, 2'b01, 9'b000000000};
    localparam logic [20:0] E_ADDIEX  = {4'd9,  3'b000, 1'b1, 2'b10, 2'b00, 9'b000000000};
    localparam logic [20:0] E_ADDIWB  = {4'd10, 3'b000, 1'b0, 2'b00, 2'b00, 9'b000000100};
    localparam logic [20:0] E_JMP     = {4'd11, 3'b000, 1'b0, 2'b00, 2'b10, 9'b000000010};

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    wire [20:0] act = {state_o, alu_op, alu_src_a, alu_src_b, pc_src, iord,
                       mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, pc_en, illegal_op};

    // Monitor: one pop and compare per cycle that has an expectation queued.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [20:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (act !== e) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
                n_checks++;
                if (mem_read && mem_write) begin
                    n_errors++;
                    $display("FAIL %s_rw_excl: got rd=%0b wr=%0b expected not both",
                             nm, mem_read, mem_write);
                end
            end
        end
    end

    // Apply one cycle of inputs just after the rising edge and queue the
    // output vector expected for that cycle.
    task automatic cyc(input logic r, input logic mr, input logic z,
                       input logic [5:0] op, input logic [20:0] e,
                       input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = RT;

        cyc(1, 1, 0, RT, E_ZERO,    "rst_hold");
        cyc(0, 0, 0, RT, E_FETCH_W, "fetch_wait");
        cyc(1, 1, 0, RT, E_ZERO,    "rst_mid_fetch");
        cyc(0, 1, 0, RT, E_FETCH_R, "fetch_after_rst");
        // R-type: 0,1,6,7
        cyc(0, 1, 0, RT, E_DEC,     "r_dec");
        cyc(0, 1, 0, RT, E_REXE,    "r_exe");
        cyc(0, 1, 0, RT, E_RWB,     "r_wb");
        // LW with two read wait cycles: 0,1,2,3,3,3,4
        cyc(0, 1, 0, LW, E_FETCH_R, "lw_fetch");
        cyc(0, 1, 0, LW, E_DEC,     "lw_dec");
        cyc(0, 1, 0, LW, E_MEMADR,  "lw_adr");
        cyc(0, 0, 0, LW, E_MEMRD,   "lw_rd_wait1");
        cyc(0, 0, 0, LW, E_MEMRD,   "lw_rd_wait2");
        cyc(0, 1, 0, LW, E_MEMRD,   "lw_rd_done");
        cyc(0, 1, 0, LW, E_MEMWB,   "lw_wb");
        // SW with one write wait cycle
        cyc(0, 1, 0, SW, E_FETCH_R, "sw_fetch");
        cyc(0, 1, 0, SW, E_DEC,     "sw_dec");
        cyc(0, 1, 0, SW, E_MEMADR,  "sw_adr");
        cyc(0, 0, 0, SW, E_MEMWR,   "sw_wr_wait");
        cyc(0, 1, 0, SW, E_MEMWR,   "sw_wr_done");
        // BEQ taken then not taken
        cyc(0, 1, 1, BQ, E_FETCH_R, "beq1_fetch");
        cyc(0, 1, 1, BQ, E_DEC,     "beq1_dec");
        cyc(0, 1, 1, BQ, E_BEQ1,    "beq1_exe");
        cyc(0, 1, 0, BQ, E_FETCH_R, "beq0_fetch");
        cyc(0, 1, 0, BQ, E_DEC,     "beq0_dec");
        cyc(0, 1, 0, BQ, E_BEQ0,    "beq0_exe");
        // Illegal opcode then jump
        cyc(0, 1, 0, BAD, E_FETCH_R, "ill_fetch");
        cyc(0, 1, 0, BAD, E_DEC_ILL, "ill_dec");
        cyc(0, 1, 0, JP,  E_FETCH_R, "ill_back_fetch");
        cyc(0, 1, 0, JP,  E_DEC,     "j_dec");
        cyc(0, 1, 0, JP,  E_JMP,     "j_exe");
        // ADDI
        cyc(0, 1, 0, AI, E_FETCH_R, "addi_fetch");
        cyc(0, 1, 0, AI, E_DEC,     "addi_dec");
        cyc(0, 1, 0, AI, E_ADDIEX,  "addi_ex");
        cyc(0, 1, 0, AI, E_ADDIWB,  "addi_wb");
        // Reset during a stalled store: the write strobe must drop at once
        cyc(0, 1, 0, SW, E_FETCH_R, "swr_fetch");
        cyc(0, 1, 0, SW, E_DEC,     "swr_dec");
        cyc(0, 0, 0, SW, E_MEMADR,  "swr_adr");
        cyc(0, 0, 0, SW, E_MEMWR,   "swr_wait");
        cyc(1, 1, 0, SW, E_ZERO,    "rst_mid_memwr");
        cyc(0, 1, 0, RT, E_FETCH_R, "fetch_after_rst2");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
